// File: rtl/dual_issue_scoreboard.sv
// Dual-issue stage: buffers one decoded pair, tracks in-flight destinations with a
// per-register latency countdown, and steers ready instructions onto the even/odd pipes.
module dual_issue_scoreboard #(
    parameter int REG_ADDR_WIDTH = 7,
    parameter int UNIT_ID_SIZE   = 3,
    parameter int LAT_WIDTH      = 3,
    parameter int INST_W         = 9 + UNIT_ID_SIZE + 4 * REG_ADDR_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst0,
    input  logic [INST_W-1:0] in_inst1,
    output logic [INST_W-1:0] even_inst_out,
    output logic [INST_W-1:0] odd_inst_out,
    output logic [15:0]       stall_cycles,
    output logic [1:0]        fsm_state
);

    localparam int R         = REG_ADDR_WIDTH;
    localparam int REG_COUNT = 1 << REG_ADDR_WIDTH;
    localparam int POS_VALID = 0;
    localparam int POS_PIPE  = 1;
    localparam int POS_WE    = 2;
    localparam int POS_USE   = 3;
    localparam int POS_LAT   = 6;
    localparam int POS_RT    = 9 + UNIT_ID_SIZE;
    localparam int POS_RA    = POS_RT + R;
    localparam int POS_RB    = POS_RA + R;
    localparam int POS_RC    = POS_RB + R;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PAIR   = 2'd1,
        S_SECOND = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [INST_W-1:0]     slot0;
    logic [INST_W-1:0]     slot1;
    logic [LAT_WIDTH-1:0]  cnt [REG_COUNT];

    logic                  ready0;
    logic                  ready1;
    logic                  conflict;
    logic                  issue0;
    logic                  issue1;
    logic                  all_issued;
    logic                  accept;
    logic                  wr0;
    logic                  wr1;
    logic [INST_W-1:0]     even_d;
    logic [INST_W-1:0]     odd_d;

    // Ready when no used source and (if writing) no destination is still counting down.
    function automatic logic inst_ready(input logic [INST_W-1:0] i,
                                        input logic [LAT_WIDTH-1:0] ca,
                                        input logic [LAT_WIDTH-1:0] cb,
                                        input logic [LAT_WIDTH-1:0] cc,
                                        input logic [LAT_WIDTH-1:0] ct);
        return !(i[POS_USE]   && ca != '0) &&
               !(i[POS_USE+1] && cb != '0) &&
               !(i[POS_USE+2] && cc != '0) &&
               !(i[POS_WE]    && ct != '0);
    endfunction

    // Structural or data reasons the younger instruction cannot join the older one.
    function automatic logic pair_conflict(input logic [INST_W-1:0] a,
                                           input logic [INST_W-1:0] b);
        logic [R-1:0] rt_a;
        logic         raw;
        logic         waw;
        rt_a = a[POS_RT +: R];
        raw  = a[POS_WE] && ((b[POS_USE]   && b[POS_RA +: R] == rt_a) ||
                             (b[POS_USE+1] && b[POS_RB +: R] == rt_a) ||
                             (b[POS_USE+2] && b[POS_RC +: R] == rt_a));
        waw  = a[POS_WE] && b[POS_WE] && (b[POS_RT +: R] == rt_a);
        return (a[POS_PIPE] == b[POS_PIPE]) || raw || waw;
    endfunction

    assign ready0 = inst_ready(slot0, cnt[slot0[POS_RA +: R]], cnt[slot0[POS_RB +: R]],
                               cnt[slot0[POS_RC +: R]], cnt[slot0[POS_RT +: R]]);
    assign ready1 = inst_ready(slot1, cnt[slot1[POS_RA +: R]], cnt[slot1[POS_RB +: R]],
                               cnt[slot1[POS_RC +: R]], cnt[slot1[POS_RT +: R]]);
    assign conflict = pair_conflict(slot0, slot1);

    // Handshake: a pair transfers on any edge where in_valid && in_ready && !flush;
    // in_ready is combinational and never depends on in_valid.
    assign in_ready  = (state_q == S_IDLE) || all_issued;
    assign accept    = in_valid && in_ready && !flush;
    assign fsm_state = state_q;

    always_comb begin
        issue0     = 1'b0;
        issue1     = 1'b0;
        all_issued = 1'b0;
        case (state_q)
            S_PAIR: begin
                issue0     = ready0 && !flush;
                issue1     = issue0 && slot1[POS_VALID] && ready1 && !conflict;
                all_issued = issue0 && (!slot1[POS_VALID] || issue1);
            end
            S_SECOND: begin
                issue1     = ready1 && !flush;
                all_issued = issue1;
            end
            default: begin
                issue0     = 1'b0;
                issue1     = 1'b0;
                all_issued = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else if (state_q == S_IDLE || all_issued) begin
            if (accept && in_inst0[POS_VALID]) begin
                state_d = S_PAIR;
            end else if (accept && in_inst1[POS_VALID]) begin
                state_d = S_SECOND;
            end else begin
                state_d = S_IDLE;
            end
        end else if (state_q == S_PAIR && issue0) begin
            state_d = S_SECOND;
        end
    end

    // Steering by the pipe bit; both issuing implies different pipes.
    always_comb begin
        even_d = '0;
        odd_d  = '0;
        if (issue0) begin
            if (slot0[POS_PIPE]) odd_d = slot0;
            else                 even_d = slot0;
        end
        if (issue1) begin
            if (slot1[POS_PIPE]) odd_d = slot1;
            else                 even_d = slot1;
        end
    end

    assign wr0 = issue0 && slot0[POS_WE];
    assign wr1 = issue1 && slot1[POS_WE];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            slot0         <= '0;
            slot1         <= '0;
            even_inst_out <= '0;
            odd_inst_out  <= '0;
            stall_cycles  <= '0;
        end else begin
            state_q       <= state_d;
            even_inst_out <= even_d;
            odd_inst_out  <= odd_d;
            if (accept) begin
                slot0 <= in_inst0;
                slot1 <= in_inst1;
            end
            if (state_q != S_IDLE && !issue0 && !issue1 && stall_cycles != 16'hFFFF) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end

    // A fresh write reloads the counter; otherwise every busy register counts down.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < REG_COUNT; r++) begin
                if (wr0 && slot0[POS_RT +: R] == R'(r)) begin
                    cnt[r] <= slot0[POS_LAT +: LAT_WIDTH];
                end else if (wr1 && slot1[POS_RT +: R] == R'(r)) begin
                    cnt[r] <= slot1[POS_LAT +: LAT_WIDTH];
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/dual_issue_scoreboard.md
# dual_issue_scoreboard

Issue stage that sits directly upstream of register fetch and the forwarding network. It takes decoded instruction pairs and tracks in-flight destination registers with a per-register latency scoreboard. It steers each instruction to the even or odd pipe, issuing two per cycle when structurally and data-independent and otherwise splitting the pair in program order. Outputs are zeroed packets when idle, so a downstream `> 0` check detects a valid issue.

## Interface
- REG_ADDR_WIDTH, 7, register address width (128 registers)
- UNIT_ID_SIZE, 3, execution-unit id width
- LAT_WIDTH, 3, latency field / scoreboard counter width
- INST_W, 9+UNIT_ID_SIZE+4*REG_ADDR_WIDTH (=40), packed instruction width
- Packed instruction layout, bit 0 first:
  - [0] valid
  - [1] pipe (0 even, 1 odd)
  - [2] we
  - [3+:3] use flags ra, rb, rc
  - [6+:3] lat
  - [9+:UNIT_ID_SIZE] unit
  - then rt, ra, rb, rc, REG_ADDR_WIDTH each
- clk  in  1  clock; the only clock
- reset  in  1  asynchronous, active-high
- flush  in  1  discard buffered, un-issued instructions
- in_valid  in  1  decode presents a pair
- in_ready  out  1  issue stage can accept the pair
- in_inst0  in  INST_W  older instruction of the pair
- in_inst1  in  INST_W  younger instruction of the pair
- even_inst_out  out  INST_W  registered even-pipe issue; all-zero when none
- odd_inst_out  out  INST_W  registered odd-pipe issue; all-zero when none
- stall_cycles  out  16  saturating count of cycles with a buffered instruction not issued

## Operation
- Buffer states:
  - IDLE: empty.
  - PAIR: slot0 and slot1 pending.
  - SECOND: only slot1 pending.
- Pair acceptance: in_valid & in_ready at an edge loads the pair.
  - Loads PAIR if in_inst0 is valid, else SECOND.
  - If neither instruction is valid, the buffer stays IDLE.
- in_ready is combinational: (state==IDLE) | (every pending instruction issues this cycle).
- Scoreboard: cnt[r], LAT_WIDTH bits per register.
  - Each edge, every nonzero cnt decrements.
  - An issuing instruction with we=1 loads cnt[rt] <= lat; the load overrides the decrement.
- An instruction X is ready when:
  - every used source s (ra/rb/rc with its use flag) has cnt[s]==0, and
  - if X.we=1, cnt[X.rt]==0 (no WAW against in-flight results).
- Issue rules:
  - PAIR: slot0 issues if ready. slot1 issues in the same cycle only if all of the following hold; otherwise state goes to SECOND:
    - slot0 issues;
    - slot1 is ready;
    - slot1.pipe != slot0.pipe;
    - no used slot1 source equals slot0.rt when slot0.we=1;
    - not (both we and equal rt).
  - SECOND: slot1 issues if ready.
  - Never issue slot1 before slot0. An invalid slot counts as already issued.
- Issued instruction is registered onto even_inst_out or odd_inst_out by its pipe bit. The other output is zero.
- flush: buffer goes to IDLE and both outputs go to zero at the next edge. Any pair offered in that cycle is discarded. The scoreboard keeps counting, because in-flight results still write.
- stall_cycles increments on any edge where the state is not IDLE and nothing issued. It saturates at 0xFFFF.

## Timing
- Reset (asynchronous): state IDLE, all cnt 0, even_inst_out/odd_inst_out 0, stall_cycles 0. in_ready=1 after reset.
- Issue latency: a pair accepted at edge t is first eligible in cycle t. Its issue appears on the outputs after edge t+1.
- Dependency spacing: a producer issued in cycle t with latency L lets a dependent issue no earlier than cycle t+L+1. L=0 gives back-to-back issue.
- Reset mid-operation drops buffered instructions immediately. No partial output is held.
- flush and reset never corrupt the pipe bit or pad bits. The outputs are either an exact copy of the input packet or all-zero.

## Test plan
- Independent pair, inst0 even (rt=5), inst1 odd (rt=6), lat 2 -> both outputs valid one edge after accept; in_ready stays high; cnt[5]=cnt[6]=2.
- Same-pipe pair, both even, independent -> inst0 on even_inst_out, then inst1 on even_inst_out the next cycle; in_ready low for one cycle; stall_cycles unchanged.
- Intra-pair RAW: inst0 even writes r10 lat 0, inst1 odd reads r10 -> inst0 issues; inst1 issues the following cycle.
- Cross-pair RAW with lat 5: producer issues cycle t, consumer of rt buffered -> consumer issues cycle t+6; stall_cycles +5.
- flush while SECOND with a new pair offered -> outputs zero next edge; offered pair not issued; state IDLE; counters continue to decrement to 0.
- Assert reset with cnt[7]=4 and a pair buffered -> outputs and stall_cycles 0 asynchronously; after release a reader of r7 issues immediately.
